// File: rtl/mem_bus_arbiter.sv
// Registered request/grant arbiter sharing one memory port among NUM_CH requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module mem_bus_arbiter #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH-1:0]        ch_wr,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
   output logic [NUM_CH*DATA_W-1:0] ch_rdata,
   output logic [NUM_CH-1:0]        ch_ready,
   output logic [NUM_CH-1:0]        ch_stall,
   output logic [ADDR_W-1:0]        addr,
   output logic [DATA_W-1:0]        data_in,
   output logic                     mem_wr,
   output logic                     mem_re,
   input  logic [DATA_W-1:0]        data_out,
   input  logic                     mem_ready
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]        state_reg;
   logic [IDX_W-1:0]  grant_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] data_in_reg;
   logic              mem_wr_reg;
   logic              mem_re_reg;

   logic [NUM_CH-1:0] pending;
   logic              start;
   logic              complete;
   logic [IDX_W-1:0]  win_idx;

   logic [ADDR_W-1:0] addr_arr  [NUM_CH];
   logic [DATA_W-1:0] wdata_arr [NUM_CH];

   assign pending  = ch_req & ~ch_ready;
   assign ch_stall = pending;
   assign start    = (state_reg == ST_IDLE) && (|pending);
   assign complete = (state_reg == ST_BUSY) && mem_ready;

   assign addr    = addr_reg;
   assign data_in = data_in_reg;
   assign mem_wr  = mem_wr_reg;
   assign mem_re  = mem_re_reg;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
         assign addr_arr[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = ch_wdata[gi*DATA_W +: DATA_W];
      end
   endgenerate

`ifdef ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] last_reg;

   // Scan from the far end back so the candidate nearest (last+1) wins.
   always_comb begin
      win_idx = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (pending[(int'(last_reg) + 1 + k) % NUM_CH]) begin
            win_idx = IDX_W'((int'(last_reg) + 1 + k) % NUM_CH);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_reg <= IDX_W'(NUM_CH - 1);
      end else if (start) begin
         last_reg <= win_idx;
      end
   end
`else
   always_comb begin
      win_idx = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (pending[k]) begin
            win_idx = IDX_W'(k);
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= ST_IDLE;
         grant_reg   <= '0;
         addr_reg    <= '0;
         data_in_reg <= '0;
         mem_wr_reg  <= 1'b0;
         mem_re_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  grant_reg   <= win_idx;
                  addr_reg    <= addr_arr[win_idx];
                  data_in_reg <= wdata_arr[win_idx];
                  mem_wr_reg  <= ch_wr[win_idx];
                  mem_re_reg  <= ~ch_wr[win_idx];
                  state_reg   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (mem_ready) begin
                  mem_wr_reg <= 1'b0;
                  mem_re_reg <= 1'b0;
                  state_reg  <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Each channel owns its read-data register; only the granted one is ever written.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
         logic              ready_reg;
         logic [DATA_W-1:0] rdata_reg;
         logic              hit;

         assign hit = complete && (grant_reg == IDX_W'(gi));

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ready_reg <= 1'b0;
               rdata_reg <= '0;
            end else begin
               ready_reg <= hit;
               if (hit && mem_re_reg) begin
                  rdata_reg <= data_out;
               end
            end
         end

         assign ch_ready[gi]                  = ready_reg;
         assign ch_rdata[gi*DATA_W +: DATA_W] = rdata_reg;
      end
   endgenerate

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (3 channels); exercises fixed priority or,
// with ARB_ROUND_ROBIN_EN defined, the round-robin grant order.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  ch_req;
   logic [2:0]  ch_wr;
   logic [95:0] ch_addr;
   logic [95:0] ch_wdata;
   logic [95:0] ch_rdata;
   logic [2:0]  ch_ready;
   logic [2:0]  ch_stall;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic        mem_wr;
   logic        mem_re;
   logic [31:0] data_out;
   logic        mem_ready;

   int n_vec = 0;
   int n_bad = 0;

   mem_bus_arbiter #(
      .NUM_CH(3),
      .ADDR_W(32),
      .DATA_W(32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ch_req   (ch_req),
      .ch_wr    (ch_wr),
      .ch_addr  (ch_addr),
      .ch_wdata (ch_wdata),
      .ch_rdata (ch_rdata),
      .ch_ready (ch_ready),
      .ch_stall (ch_stall),
      .addr     (addr),
      .data_in  (data_in),
      .mem_wr   (mem_wr),
      .mem_re   (mem_re),
      .data_out (data_out),
      .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("  ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rdata(input int ch);
      return ch_rdata[ch*32 +: 32];
   endfunction

   initial begin
      rst       = 1'b0;
      ch_req    = '0;
      ch_wr     = '0;
      ch_addr   = '0;
      ch_wdata  = '0;
      data_out  = '0;
      mem_ready = 1'b0;

      // Reset state
      tick;
      tick;
      check("rst_addr", addr, 32'h0);
      check("rst_mem_re", {31'b0, mem_re}, 32'h0);
      check("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
      check("rst_ready", {29'b0, ch_ready}, 32'h0);
      check("rst_rdata1", rdata(1), 32'h0);
      rst = 1'b1;
      tick;
      check("idle_no_req", {31'b0, mem_re}, 32'h0);

      // Single read on channel 1, memory answers three cycles after the strobe
      ch_req = 3'b010;
      ch_addr[32 +: 32] = 32'h0000_0100;
      tick;
      check("rd_addr", addr, 32'h0000_0100);
      check("rd_mem_re", {31'b0, mem_re}, 32'h1);
      check("rd_mem_wr", {31'b0, mem_wr}, 32'h0);
      check("rd_stall", {29'b0, ch_stall}, 32'h2);
      tick;
      tick;
      check("rd_hold", {31'b0, mem_re}, 32'h1);
      mem_ready = 1'b1;
      data_out  = 32'hDEAD_BEEF;
      tick;
      check("rd_ready", {29'b0, ch_ready}, 32'h2);
      check("rd_rdata1", rdata(1), 32'hDEAD_BEEF);
      check("rd_rdata0_keep", rdata(0), 32'h0);
      check("rd_re_clr", {31'b0, mem_re}, 32'h0);
      ch_req    = '0;
      mem_ready = 1'b0;
      data_out  = '0;
      tick;
      check("rd_ready_clr", {29'b0, ch_ready}, 32'h0);

      // Write on channel 0 with mem_ready tied high
      ch_req = 3'b001;
      ch_wr  = 3'b001;
      ch_addr[0 +: 32]  = 32'h0000_0040;
      ch_wdata[0 +: 32] = 32'h1234_5678;
      mem_ready = 1'b1;
      tick;
      check("wr_mem_wr", {31'b0, mem_wr}, 32'h1);
      check("wr_data_in", data_in, 32'h1234_5678);
      check("wr_addr", addr, 32'h0000_0040);
      check("wr_mem_re", {31'b0, mem_re}, 32'h0);
      tick;
      check("wr_strobe_1cyc", {31'b0, mem_wr}, 32'h0);
      check("wr_ready", {29'b0, ch_ready}, 32'h1);
      ch_req = '0;
      ch_wr  = '0;
      tick;
      check("wr_ready_clr", {29'b0, ch_ready}, 32'h0);
      mem_ready = 1'b0;

      // Abort: channel 0 drops its read request while the access is outstanding
      ch_req = 3'b001;
      ch_addr[0 +: 32] = 32'h0000_0080;
      tick;
      check("ab_mem_re", {31'b0, mem_re}, 32'h1);
      check("ab_addr", addr, 32'h0000_0080);
      ch_req = '0;
      tick;
      check("ab_hold", {31'b0, mem_re}, 32'h1);
      mem_ready = 1'b1;
      data_out  = 32'h0000_0077;
      tick;
      check("ab_ready", {29'b0, ch_ready}, 32'h1);
      check("ab_rdata0", rdata(0), 32'h0000_0077);
      mem_ready = 1'b0;
      tick;
      check("ab_ready_clr", {29'b0, ch_ready}, 32'h0);
      tick;
      check("ab_idle", {31'b0, mem_re}, 32'h0);

      // Asynchronous reset in the middle of a read
      ch_req = 3'b100;
      ch_addr[64 +: 32] = 32'h0000_055C;
      tick;
      check("ar_mem_re", {31'b0, mem_re}, 32'h1);
      #3;
      rst    = 1'b0;
      ch_req = '0;
      #1;
      check("ar_re_async", {31'b0, mem_re}, 32'h0);
      check("ar_wr_async", {31'b0, mem_wr}, 32'h0);
      check("ar_addr_async", addr, 32'h0);
      check("ar_ready_async", {29'b0, ch_ready}, 32'h0);
      check("ar_rdata1_async", rdata(1), 32'h0);
      tick;
      rst = 1'b1;
      tick;
      tick;
      check("ar_post_idle_re", {31'b0, mem_re}, 32'h0);
      check("ar_post_idle_wr", {31'b0, mem_wr}, 32'h0);

      // Contention between continuously requesting channels
      ch_addr[0 +: 32]  = 32'h0000_0200;
      ch_addr[32 +: 32] = 32'h0000_0300;
      ch_addr[64 +: 32] = 32'h0000_0400;
      ch_wr     = '0;
      mem_ready = 1'b1;
`ifndef ARB_ROUND_ROBIN_EN
      data_out = 32'hA5A5_0001;
      ch_req   = 3'b011;
      for (int n = 0; n < 3; n++) begin
         tick;
         check($sformatf("fp_busy_addr%0d", n), addr, 32'h0000_0200);
         check($sformatf("fp_busy_stall%0d", n), {29'b0, ch_stall}, 32'h3);
         tick;
         check($sformatf("fp_ready%0d", n), {29'b0, ch_ready}, 32'h1);
         check($sformatf("fp_stall1_%0d", n), {29'b0, ch_stall}, 32'h2);
         tick;
         check($sformatf("fp_idle%0d", n), {29'b0, ch_ready}, 32'h0);
      end
      ch_req   = 3'b010;
      data_out = 32'h0BAD_F00D;
      tick;
      check("fp_ch1_addr", addr, 32'h0000_0300);
      check("fp_ch1_re", {31'b0, mem_re}, 32'h1);
      tick;
      check("fp_ch1_ready", {29'b0, ch_ready}, 32'h2);
      check("fp_ch1_rdata", rdata(1), 32'h0BAD_F00D);
      check("fp_ch0_rdata", rdata(0), 32'hA5A5_0001);
      ch_req = '0;
      tick;
      check("fp_done_clr", {29'b0, ch_ready}, 32'h0);
`else
      ch_req = 3'b111;
      for (int n = 0; n < 6; n++) begin
         logic [31:0] exp_addr;
         logic [2:0]  exp_rdy;
         exp_addr = 32'h0000_0200 + 32'(n % 3) * 32'h100;
         exp_rdy  = 3'(1 << (n % 3));
         tick;
         check($sformatf("rr_addr%0d", n), addr, exp_addr);
         tick;
         check($sformatf("rr_ready%0d", n), {29'b0, ch_ready}, {29'b0, exp_rdy});
         tick;
      end
      ch_req = '0;
      tick;
      check("rr_idle", {31'b0, mem_re}, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised N-channel arbiter that shares one memory port between several requesters, for example instruction fetch, data load/store and future DMA.
- Replaces the fixed two-way combinational address/data bus steering at the processor top with a registered request/grant FSM.
- Sits between the pipeline stages and the single external memory interface (data_out/data_in/addr/mem_wr/mem_re/mem_ready).

Parameters:
- NUM_CH, 2, number of requesting channels (1..8); channel 0 has highest fixed priority.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- ch_req  input  NUM_CH  per-channel request; level, held until the matching ch_ready pulse.
- ch_wr  input  NUM_CH  per-channel 1=write, 0=read.
- ch_addr  input  NUM_CH*ADDR_W  flattened addresses; channel i at bits [i*ADDR_W +: ADDR_W].
- ch_wdata  input  NUM_CH*DATA_W  flattened write data.
- ch_rdata  output  NUM_CH*DATA_W  flattened registered read data, one register per channel.
- ch_ready  output  NUM_CH  one-cycle completion pulse per channel.
- ch_stall  output  NUM_CH  ch_req[i] & ~ch_ready[i]; combinational, drives pipeline stall.
- addr  output  ADDR_W  memory address, registered.
- data_in  output  DATA_W  memory write data, registered.
- mem_wr  output  1  memory write strobe, registered.
- mem_re  output  1  memory read strobe, registered.
- data_out  input  DATA_W  memory read data.
- mem_ready  input  1  memory access complete, sampled on clk rising edge.

Behaviour:
- Reset (rst low, async) sets:
  - state=IDLE, grant=0;
  - addr, data_in, ch_rdata all 0;
  - mem_wr=0, mem_re=0, ch_ready=0.
- States:
  - IDLE: no access outstanding.
  - BUSY: strobe asserted, waiting for mem_ready.
  - DONE: one cycle; ch_ready pulse; returns to IDLE.
- IDLE, if any ch_req[i]=1 and ch_ready[i]=0:
  - select the winner (lowest index by default);
  - latch grant, addr=ch_addr[g], data_in=ch_wdata[g];
  - set mem_wr=ch_wr[g], mem_re=~ch_wr[g];
  - go BUSY.
- BUSY:
  - Strobes and address are held constant.
  - On mem_ready=1: clear mem_wr/mem_re; if read, ch_rdata[g]<=data_out; set ch_ready[g]=1; go DONE.
  - The other ch_rdata entries are never disturbed.
- DONE: ch_ready cleared; go IDLE. Arbitration resumes the next cycle, so at most one access per 3 cycles.
- Latency:
  - Request seen at edge 0 → strobe high after edge 1.
  - mem_ready sampled at edge k → ch_ready high for one cycle after edge k.
  - Minimum 2 cycles request-to-ready when mem_ready is tied high.
- mem_ready while IDLE or DONE: ignored.
- Simultaneous requests: one winner per arbitration; losers keep ch_stall=1 until served.
- ch_req dropped during BUSY: the access still completes and ch_ready still pulses; the requester discards it. An aborted write therefore still reaches memory.
- Request changed during BUSY: the latched copy is used; inputs are not re-sampled.
- Reset mid-BUSY: strobes drop immediately (async) and the access is abandoned.
- NUM_CH=1: the arbiter degenerates to a registered pass-through with the same FSM and timing.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Arbitration is round-robin: a pointer holds the last-granted index.
  - Search starts at (last+1) mod NUM_CH and wraps to 0.
  - The pointer resets to NUM_CH-1, so the first grant is channel 0.
  - The pointer updates only on entering BUSY.
- Undefined: fixed priority with the lowest index winning; no pointer register is synthesised.

Test Plan:
- Reset: drive rst low mid-BUSY with mem_re=1 → mem_re, mem_wr, ch_ready and addr go to 0 without a clock edge; after release and with no requests the FSM stays IDLE.
- Single read: ch_req[1]=1, ch_addr[1]=0x100, mem_ready high 3 cycles after mem_re with data_out=0xDEADBEEF → addr=0x100, mem_re=1, then ch_ready[1] one-cycle pulse and ch_rdata[1]=0xDEADBEEF; ch_rdata[0] unchanged.
- Write: ch0 write, addr 0x40, wdata 0x12345678, mem_ready tied high → mem_wr=1 for exactly 1 cycle with data_in=0x12345678; ch_ready[0] pulses 2 cycles after the request.
- Contention, fixed priority: ch0 and ch1 request together, repeatedly re-requesting → ch0 served every access and ch1 stalled with ch_stall[1]=1; once ch0 drops its request, ch1 is served.
- Contention, ARB_ROUND_ROBIN_EN, NUM_CH=3: all three request continuously → grant order 0,1,2,0,1,2.
- Abort: ch_req[0] dropped during BUSY → the memory access completes, ch_ready[0] still pulses once, and the FSM returns to IDLE with no hang.
